// File: rtl/sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_drive_ctrl
// Brief    : Debounced push-button front end producing one-hot, fixed-width
//            S/R pulses for an S-R latch, with tie arbitration and idle gap.
// Revision : 1.0
// ============================================================================
module sr_drive_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int RESET_PRIORITY  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic rst_btn,
  output logic S,
  output logic R,
  output logic busy
);

  localparam int c_DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_PW  = $clog2(PULSE_CYCLES + 1);
  localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PW-1:0]  c_P_LAST  = c_PW'(PULSE_CYCLES - 1);
  localparam logic             c_R_WINS  = (RESET_PRIORITY != 0);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PULSE_S = 2'd1;
  localparam logic [1:0] c_PULSE_R = 2'd2;
  localparam logic [1:0] c_GAP     = 2'd3;

  // Channel 0 carries the set request, channel 1 the reset request.
  logic [1:0] w_btn;
  logic [1:0] w_rise;

  assign w_btn = {rst_btn, set_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_stable_d;
    logic [c_DBW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1       <= 1'b0;
        r_s2       <= 1'b0;
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_s1       <= w_btn[gi];
        r_s2       <= r_s1;
        r_stable_d <= r_stable;
        if (r_s2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + c_DBW'(1);
        end
      end
    end

    assign w_rise[gi] = r_stable & ~r_stable_d;
  end

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_PW-1:0] r_pcnt;
  logic [c_PW-1:0] w_pcnt_nxt;
  logic            r_set_pend;
  logic            r_rst_pend;
  logic            w_set_pend_nxt;
  logic            w_rst_pend_nxt;
  logic            w_req_s;
  logic            w_req_r;
  logic            r_s;
  logic            r_r;
  logic            w_s_nxt;
  logic            w_r_nxt;

  // While idle, a request left pending by a gap exit is served like a fresh rise.
  assign w_req_s = w_rise[0] | r_set_pend;
  assign w_req_r = w_rise[1] | r_rst_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_pcnt     <= '0;
      r_set_pend <= 1'b0;
      r_rst_pend <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_set_pend <= w_set_pend_nxt;
      r_rst_pend <= w_rst_pend_nxt;
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pcnt_nxt     = '0;
    w_set_pend_nxt = r_set_pend | (w_rise[0] & (r_state != c_IDLE));
    w_rst_pend_nxt = r_rst_pend | (w_rise[1] & (r_state != c_IDLE));
    case (r_state)
      c_IDLE: begin
        if (w_req_s && w_req_r) begin
          w_state_nxt    = c_R_WINS ? c_PULSE_R : c_PULSE_S;
          w_set_pend_nxt = c_R_WINS;
          w_rst_pend_nxt = ~c_R_WINS;
        end else if (w_req_s) begin
          w_state_nxt    = c_PULSE_S;
          w_set_pend_nxt = 1'b0;
        end else if (w_req_r) begin
          w_state_nxt    = c_PULSE_R;
          w_rst_pend_nxt = 1'b0;
        end
      end
      c_PULSE_S, c_PULSE_R: begin
        if (r_pcnt == c_P_LAST) begin
          w_state_nxt = c_GAP;
        end else begin
          w_pcnt_nxt = r_pcnt + c_PW'(1);
        end
      end
      c_GAP: begin
        // The served bit clears, but a rise landing on this same edge re-arms it.
        if (r_set_pend && r_rst_pend) begin
          if (c_R_WINS) begin
            w_state_nxt    = c_PULSE_R;
            w_rst_pend_nxt = w_rise[1];
          end else begin
            w_state_nxt    = c_PULSE_S;
            w_set_pend_nxt = w_rise[0];
          end
        end else if (r_set_pend) begin
          w_state_nxt    = c_PULSE_S;
          w_set_pend_nxt = w_rise[0];
        end else if (r_rst_pend) begin
          w_state_nxt    = c_PULSE_R;
          w_rst_pend_nxt = w_rise[1];
        end else begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_s_nxt = (w_state_nxt == c_PULSE_S);
    w_r_nxt = (w_state_nxt == c_PULSE_R);
  end

  assign S    = r_s;
  assign R    = r_r;
  assign busy = (r_state != c_IDLE) | r_set_pend | r_rst_pend;

endmodule
`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_drive_ctrl
// Brief    : Randomised and directed bench for sr_drive_ctrl against a
//            cycle-level behavioural model of debounce, arbitration and pulses.
// Revision : 1.0
// ============================================================================
module tb_sr_drive_ctrl;

  localparam int DEB = 4;
  localparam int PW  = 2;
  localparam int RP  = 1;

  logic clk = 1'b0;
  logic rst;
  logic set_btn;
  logic rst_btn;
  logic S;
  logic R;
  logic busy;

  int checks = 0;
  int errors = 0;

  sr_drive_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PW),
    .RESET_PRIORITY (RP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .set_btn(set_btn),
    .rst_btn(rst_btn),
    .S      (S),
    .R      (R),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 = set request, 1 = reset request.
  bit m_s1[2];
  bit m_s2[2];
  bit m_stab[2];
  bit m_stab_d[2];
  bit m_run_v[2];
  int m_run_n[2];
  bit m_rise[2];
  bit m_rq[2];
  bit m_pend[2];
  int m_active = -1;  // which pulse is being driven, -1 = none
  bit m_gap = 1'b0;
  int m_left = 0;
  int m_win;
  int m_lose;
  int m_pick;
  bit m_S = 1'b0;
  bit m_R = 1'b0;
  bit m_busy = 1'b0;

  always @(posedge clk) begin
    m_win  = (RP != 0) ? 1 : 0;
    m_lose = 1 - m_win;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_stab_d[i] = 0;
        m_run_v[i] = 0; m_run_n[i] = 0; m_pend[i] = 0;
      end
      m_active = -1;
      m_gap    = 0;
      m_left   = 0;
    end else begin
      for (int i = 0; i < 2; i++) m_rise[i] = m_stab[i] && !m_stab_d[i];
      if (m_gap) begin
        m_gap  = 0;
        m_pick = -1;
        if (m_pend[m_win]) m_pick = m_win;
        else if (m_pend[m_lose]) m_pick = m_lose;
        if (m_pick >= 0) begin
          m_pend[m_pick] = 0;
          m_active = m_pick;
          m_left   = PW;
        end
        for (int i = 0; i < 2; i++) if (m_rise[i]) m_pend[i] = 1;
      end else if (m_active >= 0) begin
        for (int i = 0; i < 2; i++) if (m_rise[i]) m_pend[i] = 1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_active = -1;
          m_gap    = 1;
        end
      end else begin
        for (int i = 0; i < 2; i++) m_rq[i] = m_rise[i] | m_pend[i];
        if (m_rq[m_win]) begin
          m_active = m_win;
          m_pend[m_win] = 0;
          if (m_rq[m_lose]) m_pend[m_lose] = 1;
        end else if (m_rq[m_lose]) begin
          m_active = m_lose;
          m_pend[m_lose] = 0;
        end
        if (m_active >= 0) m_left = PW;
      end
      // A level is accepted once the synchronised input has held it DEB samples.
      for (int i = 0; i < 2; i++) begin
        m_stab_d[i] = m_stab[i];
        if (m_s2[i] == m_run_v[i]) m_run_n[i] = m_run_n[i] + 1;
        else begin
          m_run_v[i] = m_s2[i];
          m_run_n[i] = 1;
        end
        if (m_run_v[i] != m_stab[i] && m_run_n[i] >= DEB) m_stab[i] = m_run_v[i];
        m_s2[i] = m_s1[i];
      end
      m_s1[0] = set_btn;
      m_s1[1] = rst_btn;
    end
    m_S    = (m_active == 0);
    m_R    = (m_active == 1);
    m_busy = (m_active >= 0) || m_gap || m_pend[0] || m_pend[1];
  end

  logic p_S = 1'b0;
  logic p_R = 1'b0;
  int   s_rises = 0;
  int   r_rises = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model after the previous edge, then drive the next one.
  task automatic tick(input logic r, input logic sb, input logic rb);
    @(negedge clk);
    chk("S", S, m_S);
    chk("R", R, m_R);
    chk("busy", busy, m_busy);
    chk("S_and_R", S & R, 1'b0);
    if (S === 1'b1 && p_S !== 1'b1) s_rises++;
    if (R === 1'b1 && p_R !== 1'b1) r_rises++;
    p_S = S;
    p_R = R;
    rst     = r;
    set_btn = sb;
    rst_btn = rb;
  endtask

  bit  exp_s[13] = '{0,0,0,0,0,0,0,0,0,1,1,0,0};
  bit  exp_r[13] = '{0,0,0,0,0,0,1,1,0,0,0,0,0};
  bit  exp_b[13] = '{0,0,0,0,0,0,1,1,1,1,1,1,0};
  bit  found;
  int  hold_s;
  int  hold_r;
  bit  lvl_s;
  bit  lvl_r;
  bit  tog;

  initial begin
    rst = 1'b1; set_btn = 1'b0; rst_btn = 1'b0;

    // Reset held with both buttons pressed.
    tick(1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_S", S, 1'b0);
      chk("rst_R", R, 1'b0);
    end
    tick(0, 1, 1);
    for (int j = 0; j <= 12; j++) begin
      tick(0, 1, 1);
      chk($sformatf("lit_S_%0d", j), S, exp_s[j]);
      chk($sformatf("lit_R_%0d", j), R, exp_r[j]);
      chk($sformatf("lit_busy_%0d", j), busy, exp_b[j]);
    end
    for (int i = 0; i < 20; i++) tick(0, 0, 0);

    // Single set press, then release.
    s_rises = 0; r_rises = 0;
    for (int i = 0; i < 20; i++) tick(0, 1, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    chk_int("single_s_pulses", s_rises, 1);
    chk_int("single_r_pulses", r_rises, 0);
    chk("single_idle", busy, 1'b0);

    // Bouncing set input with runs shorter than the debounce window.
    s_rises = 0;
    tog = 1'b1;
    for (int n = 0; n < 30; ) begin
      hold_s = $urandom_range(1, DEB - 1);
      for (int k = 0; k < hold_s; k++) tick(0, tog, 0);
      n += hold_s;
      tog = ~tog;
    end
    for (int i = 0; i < 12; i++) tick(0, 0, 0);
    chk_int("bounce_no_pulse", s_rises, 0);
    for (int i = 0; i < 8; i++) tick(0, 1, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    chk_int("bounce_then_hold", s_rises, 1);

    // Simultaneous press.
    s_rises = 0; r_rises = 0;
    for (int i = 0; i < 10; i++) tick(0, 1, 1);
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    chk_int("simul_s_pulses", s_rises, 1);
    chk_int("simul_r_pulses", r_rises, 1);

    // Set rise landing during the R pulse, then a later second set press.
    s_rises = 0; r_rises = 0;
    tick(0, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 1, 1);
    for (int i = 0; i < 2; i++) tick(0, 0, 1);
    for (int i = 0; i < 2; i++) tick(0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 1, 0);
    for (int i = 0; i < 25; i++) tick(0, 0, 0);
    chk_int("overlap_r_pulses", r_rises, 1);
    chk_int("overlap_s_pulses", s_rises, 2);

    // Reset asserted on the first cycle of an S pulse.
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, 0);
      if (m_S) begin
        found = 1'b1;
        rst = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL midpulse_timeout: got no S pulse expected one within 30 cycles");
    end
    tick(0, 0, 0);
    chk("midrst_S", S, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    s_rises = 0;
    for (int i = 0; i < 20; i++) tick(0, 0, 0);
    chk_int("midrst_no_pulse", s_rises, 0);

    // Randomised buttons with occasional reset.
    hold_s = 0; hold_r = 0; lvl_s = 0; lvl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_s == 0) begin
        lvl_s  = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 10);
      end
      if (hold_r == 0) begin
        lvl_r  = 1'($urandom_range(0, 1));
        hold_r = $urandom_range(1, 10);
      end
      hold_s--;
      hold_r--;
      tick(($urandom_range(0, 299) == 0), lvl_s, lvl_r);
    end
    for (int i = 0; i < 20; i++) tick(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
